// File: rtl/subbank_port_arb.sv
// Two-port write / two-port read arbiter in front of a single sub-bank.
// Writes are combinational with round-robin grant; reads go through a
// two-state FSM (accept, then wait one cycle for mem_rdata) with their own
// round-robin pointer and a same-address write hazard stall.
// Optional performance counters are built only when SUBBANK_ARB_PERF_EN is
// defined; otherwise the perf ports read as zero.
//
// state  | meaning
// R_IDLE | free to accept a read (subject to write hazard)
// R_WAIT | read issued last cycle, capture mem_rdata on closing edge
module subbank_port_arb #(
    parameter int LINE_WIDTH = 400,
    parameter int DEPTH      = 1024,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wr_valid,
    output logic [1:0]            wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr0,
    input  logic [ADDR_W-1:0]     wr_addr1,
    input  logic [LINE_WIDTH-1:0] wr_data0,
    input  logic [LINE_WIDTH-1:0] wr_data1,
    input  logic [1:0]            rd_valid,
    output logic [1:0]            rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr0,
    input  logic [ADDR_W-1:0]     rd_addr1,
    output logic [1:0]            rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_rd_stall_cnt
);

    typedef enum logic {R_IDLE, R_WAIT} rd_state_e;

    rd_state_e             state_q, state_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;
    logic                  rid_q, rid_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [1:0]            wr_gnt;
    logic [1:0]            rd_cand;
    logic [1:0]            rd_gnt;
    logic [ADDR_W-1:0]     rd_cand_addr;
    logic                  hazard;

    // Write grant: single requester wins outright, contention goes to wr_ptr.
    always_comb begin
        wr_gnt   = 2'b00;
        wr_ptr_d = wr_ptr_q;
        if (!rst) begin
            case (wr_valid)
                2'b01:   wr_gnt = 2'b01;
                2'b10:   wr_gnt = 2'b10;
                2'b11:   wr_gnt = wr_ptr_q ? 2'b10 : 2'b01;
                default: wr_gnt = 2'b00;
            endcase
        end
        if (wr_gnt != 2'b00) wr_ptr_d = wr_gnt[0];
        mem_we    = |wr_gnt;
        mem_waddr = wr_gnt[1] ? wr_addr1 : wr_addr0;
        mem_wdata = wr_gnt[1] ? wr_data1 : wr_data0;
    end

    // Read FSM next state, read grant with hazard stall, response capture.
    always_comb begin
        case (rd_valid)
            2'b01:   rd_cand = 2'b01;
            2'b10:   rd_cand = 2'b10;
            2'b11:   rd_cand = rd_ptr_q ? 2'b10 : 2'b01;
            default: rd_cand = 2'b00;
        endcase
        rd_cand_addr = rd_cand[1] ? rd_addr1 : rd_addr0;
        hazard       = mem_we && (rd_cand_addr == mem_waddr);

        state_d     = state_q;
        rd_gnt      = 2'b00;
        rd_ptr_d    = rd_ptr_q;
        raddr_d     = raddr_q;
        rid_d       = rid_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        mem_re      = 1'b0;
        mem_raddr   = raddr_q;

        case (state_q)
            R_IDLE: begin
                if (!rst && (rd_cand != 2'b00) && !hazard) begin
                    rd_gnt    = rd_cand;
                    mem_re    = 1'b1;
                    mem_raddr = rd_cand_addr;
                    raddr_d   = rd_cand_addr;
                    rid_d     = rd_cand[1];
                    rd_ptr_d  = rd_cand[0];
                    state_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                rsp_valid_d = rid_q ? 2'b10 : 2'b01;
                rsp_data_d  = mem_rdata;
                state_d     = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Arbiter and read-path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= R_IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            raddr_q     <= '0;
            rid_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            raddr_q     <= raddr_d;
            rid_q       <= rid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef SUBBANK_ARB_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_st_q, perf_st_d;

    // Saturating event counters.
    always_comb begin
        perf_wr_d = perf_wr_q;
        perf_rd_d = perf_rd_q;
        perf_st_d = perf_st_q;
        if ((wr_gnt != 2'b00) && (perf_wr_q != 32'hFFFF_FFFF)) perf_wr_d = perf_wr_q + 32'd1;
        if ((rd_gnt != 2'b00) && (perf_rd_q != 32'hFFFF_FFFF)) perf_rd_d = perf_rd_q + 32'd1;
        if ((rd_valid != 2'b00) && (rd_gnt == 2'b00) && (perf_st_q != 32'hFFFF_FFFF))
            perf_st_d = perf_st_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_q <= '0;
            perf_rd_q <= '0;
            perf_st_q <= '0;
        end else begin
            perf_wr_q <= perf_wr_d;
            perf_rd_q <= perf_rd_d;
            perf_st_q <= perf_st_d;
        end
    end

    assign perf_wr_cnt       = perf_wr_q;
    assign perf_rd_cnt       = perf_rd_q;
    assign perf_rd_stall_cnt = perf_st_q;
`else
    assign perf_wr_cnt       = '0;
    assign perf_rd_cnt       = '0;
    assign perf_rd_stall_cnt = '0;
`endif

endmodule
